// File: rtl/jt03_bm_pkg.sv
// Shared types and constants for the jt03 bus master.
package jt03_bm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_GAP,
        ST_DATA,
        ST_POLL
    } bm_state_t;

    // Bit of the jt03 status byte that reports a write still in progress.
    localparam int BUSY_BIT = 7;

    // jt03 a0 select: 0 latches a register number, 1 writes its value.
    localparam logic PORT_ADDR = 1'b0;
    localparam logic PORT_DATA = 1'b1;

endpackage

// File: rtl/jt03_bm_fifo.sv
// Circular request queue holding {register, value} pairs for the bus master.
module jt03_bm_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [15:0]              din,
    input  logic                     pop,
    output logic [15:0]              dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/jt03_bus_master.sv
// Drives the jt03 CPU port from a queue of register writes: address cycle,
// idle gap, data cycle, then polls the busy flag before the next write.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | bus released; pops the next request when one is queued
// ST_ADDR  | one cen-cycle strobing the register number on a0=0
// ST_GAP   | bus released for ADDR_GAP cen-cycles between the strobes
// ST_DATA  | one cen-cycle strobing the value on a0=1
// ST_POLL  | chip selected, reading status until busy clears or timeout
module jt03_bus_master
    import jt03_bm_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_GAP   = 2,
    parameter int POLL_LIMIT = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cen,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [7:0]                    req_reg,
    input  logic [7:0]                    req_data,
    output logic [7:0]                    ym_din,
    output logic                          ym_addr,
    output logic                          ym_cs_n,
    output logic                          ym_wr_n,
    input  logic [7:0]                    ym_dout,
    output logic                          busy,
    output logic                          err_timeout,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int             GW        = $clog2(ADDR_GAP) + 1;
    localparam logic [GW-1:0]  GAP_INIT  = GW'(ADDR_GAP - 1);
    localparam logic [7:0]     POLL_LIM8 = 8'(POLL_LIMIT);

    bm_state_t     state;
    bm_state_t     state_nxt;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    poll_cnt;
    logic [7:0]    poll_inc;
    logic [7:0]    data_q;
    logic [15:0]   fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          busy_hi;
    logic          poll_expire;

    logic          cs_n_nxt;
    logic          wr_n_nxt;
    logic          addr_nxt;
    logic [7:0]    din_nxt;

    // Only the busy flag of the status byte matters here.
    logic          unused_dout;
    assign unused_dout = ^ym_dout[6:0];

    jt03_bm_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid),
        .din   ({req_reg, req_data}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign req_ready   = ~fifo_full;
    assign busy        = (level != '0) | (state != ST_IDLE);
    assign pop         = cen & (state == ST_IDLE) & ~fifo_empty;
    assign busy_hi     = ym_dout[BUSY_BIT];
    assign poll_inc    = poll_cnt + 8'd1;
    assign poll_expire = busy_hi & (poll_inc == POLL_LIM8);

    // State register, advancing only on clock-enable pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (cen) begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (!fifo_empty)            state_nxt = ST_ADDR;
            ST_ADDR:                             state_nxt = ST_GAP;
            ST_GAP:  if (gap_cnt == '0)          state_nxt = ST_DATA;
            ST_DATA:                             state_nxt = ST_POLL;
            ST_POLL: if (!busy_hi || poll_expire) state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    // Bus values for the state being entered; registered below so the pins
    // never see a combinational path. ADDR is only entered from IDLE in the
    // same edge as the pop, so the register number comes straight off the
    // queue head.
    always_comb begin
        cs_n_nxt = 1'b1;
        wr_n_nxt = 1'b1;
        addr_nxt = PORT_ADDR;
        din_nxt  = ym_din;
        unique case (state_nxt)
            ST_ADDR: begin
                cs_n_nxt = 1'b0;
                wr_n_nxt = 1'b0;
                din_nxt  = fifo_dout[15:8];
            end
            ST_DATA: begin
                cs_n_nxt = 1'b0;
                wr_n_nxt = 1'b0;
                addr_nxt = PORT_DATA;
                din_nxt  = data_q;
            end
            ST_POLL: begin
                cs_n_nxt = 1'b0;
            end
            default: begin
                cs_n_nxt = 1'b1;
            end
        endcase
    end

    // Registered bus pins; strobes release asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ym_cs_n <= 1'b1;
            ym_wr_n <= 1'b1;
            ym_addr <= PORT_ADDR;
            ym_din  <= 8'h00;
        end else if (cen) begin
            ym_cs_n <= cs_n_nxt;
            ym_wr_n <= wr_n_nxt;
            ym_addr <= addr_nxt;
            ym_din  <= din_nxt;
        end
    end

    // Latched value, gap/poll counters and the sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q      <= 8'h00;
            gap_cnt     <= '0;
            poll_cnt    <= 8'h00;
            err_timeout <= 1'b0;
        end else if (cen) begin
            if (pop) begin
                data_q <= fifo_dout[7:0];
            end
            unique case (state)
                ST_ADDR: gap_cnt <= GAP_INIT;
                ST_GAP:  if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
                ST_DATA: poll_cnt <= 8'h00;
                ST_POLL: begin
                    if (busy_hi) begin
                        poll_cnt <= poll_inc;
                    end
                    if (poll_expire) begin
                        err_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jt03_bus_master.sv
// Testbench for jt03_bus_master: random requests checked against a
// transaction-level model of the expected bus cycles.
module tb_jt03_bus_master;

    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int PLIM  = 255;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cen = 1'b1;
    logic          req_valid;
    logic          req_ready;
    logic [7:0]    req_reg;
    logic [7:0]    req_data;
    logic [7:0]    ym_din;
    logic          ym_addr;
    logic          ym_cs_n;
    logic          ym_wr_n;
    logic [7:0]    ym_dout;
    logic          busy;
    logic          err_timeout;
    logic [LW-1:0] level;

    jt03_bus_master #(
        .FIFO_DEPTH (DEPTH),
        .ADDR_GAP   (GAP),
        .POLL_LIMIT (PLIM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cen         (cen),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_reg     (req_reg),
        .req_data    (req_data),
        .ym_din      (ym_din),
        .ym_addr     (ym_addr),
        .ym_cs_n     (ym_cs_n),
        .ym_wr_n     (ym_wr_n),
        .ym_dout     (ym_dout),
        .busy        (busy),
        .err_timeout (err_timeout),
        .level       (level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       cs_n;
        logic       wr_n;
        logic       addr;
        logic [7:0] din;
    } bus_t;

    typedef struct packed {
        logic [7:0]  rg;
        logic [7:0]  dat;
        logic [15:0] gap;
        logic [15:0] polls;
    } txn_t;

    int   n_assert = 0;
    int   n_fail   = 0;
    bus_t trace[$];
    txn_t exp_q[$];
    int   busy_len = 0;
    int   busy_cnt = 0;
    bit   prev_poll = 1'b0;
    bit   stab_en = 1'b0;
    bus_t last_bus;
    logic cen_q;
    bit   cen_on = 1'b1;
    bit   cen_div = 1'b0;
    int   phase = 0;

    // Chip model: busy stays high for busy_len poll cycles after each data write.
    assign ym_dout = {(busy_cnt != 0), 7'h00};

    // Clock-enable generator: steady or one pulse every third clock.
    always @(posedge clk) begin
        #1;
        phase = (phase == 2) ? 0 : phase + 1;
        cen = cen_div ? (phase == 0) : cen_on;
    end

    always @(posedge clk) cen_q <= cen;

    // Records one bus snapshot per cen-cycle and checks hold between pulses.
    always @(negedge clk) begin : mon_blk
        bus_t cur;
        cur = {ym_cs_n, ym_wr_n, ym_addr, ym_din};
        if (cen_q === 1'b1) begin
            if (prev_poll && busy_cnt > 0) busy_cnt--;
            if (!cur.cs_n && !cur.wr_n && cur.addr) busy_cnt = busy_len;
            prev_poll = !cur.cs_n && cur.wr_n;
            trace.push_back(cur);
            last_bus = cur;
        end else if (stab_en) begin
            n_assert++;
            assert (cur === last_bus) else begin
                n_fail++;
                $error("FAIL stable: observed %h expected %h", cur, last_bus);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] r, input logic [7:0] d, input int maxw);
        bit   done;
        txn_t t;
        done = 1'b0;
        req_reg = r;
        req_data = d;
        req_valid = 1'b1;
        for (int i = 0; i < maxw && !done; i++) begin
            if (req_ready === 1'b1) done = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        n_assert++;
        if (done) begin
            t.rg = r;
            t.dat = d;
            t.gap = 16'(GAP);
            t.polls = (busy_len + 1 >= PLIM) ? 16'(PLIM) : 16'(busy_len + 1);
            exp_q.push_back(t);
        end else begin
            n_fail++;
            $error("FAIL push_wait: observed req_ready %0b expected 1", req_ready);
        end
    endtask

    task automatic wait_idle(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (busy === 1'b0) break;
            tick();
        end
        check("idle_busy", busy, 0);
        repeat (6) tick();
    endtask

    // Rebuilds transactions from the cen-cycle trace and compares to the model.
    task automatic compare_txns(input string tag);
        txn_t obs[$];
        txn_t t;
        int   i;
        i = 0;
        while (i < trace.size()) begin
            if (!trace[i].cs_n && !trace[i].wr_n && !trace[i].addr) begin
                t = '0;
                t.rg = trace[i].din;
                i++;
                while (i < trace.size() && trace[i].cs_n) begin
                    t.gap = t.gap + 16'd1;
                    i++;
                end
                if (i < trace.size() && !trace[i].cs_n && !trace[i].wr_n && trace[i].addr) begin
                    t.dat = trace[i].din;
                    i++;
                    while (i < trace.size() && !trace[i].cs_n && trace[i].wr_n) begin
                        t.polls = t.polls + 16'd1;
                        i++;
                    end
                end
                obs.push_back(t);
            end else begin
                i++;
            end
        end
        check({tag, "_count"}, obs.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < obs.size(); k++) begin
            check($sformatf("%s_txn%0d", tag, k), obs[k], exp_q[k]);
        end
        exp_q.delete();
        trace.delete();
    endtask

    initial begin
        bit seen_addr;
        bit in_gap;
        rst = 1'b1;
        req_valid = 1'b0;
        req_reg = 8'h00;
        req_data = 8'h00;
        repeat (3) tick();

        check("rst_cs_n", ym_cs_n, 1);
        check("rst_wr_n", ym_wr_n, 1);
        check("rst_addr", ym_addr, 0);
        check("rst_din", ym_din, 0);
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_err", err_timeout, 0);
        check("rst_level", level, 0);

        rst = 1'b0;
        tick();
        trace.delete();

        // Single write with the chip never busy.
        busy_len = 0;
        push(8'h28, 8'hF1, 4);
        wait_idle(100);
        check("single_err", err_timeout, 0);
        compare_txns("single");

        // Busy for 10 polls on each write.
        busy_len = 10;
        repeat (2) push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4);
        wait_idle(200);
        check("busy10_err", err_timeout, 0);
        compare_txns("busy10");

        // Fill the queue with the FSM frozen, then release it.
        cen_on = 1'b0;
        tick();
        tick();
        busy_len = $urandom_range(0, 3);
        repeat (4) push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4);
        check("full_level", level, 4);
        check("full_ready", req_ready, 0);
        req_reg = 8'hA5;
        req_data = 8'h5A;
        req_valid = 1'b1;
        tick();
        tick();
        req_valid = 1'b0;
        check("full_ignored", level, 4);
        cen_on = 1'b1;
        push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 20);
        wait_idle(400);
        compare_txns("burst");

        // Clock enable pulsing every third clock.
        cen_div = 1'b1;
        stab_en = 1'b1;
        busy_len = 2;
        repeat (3) push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 10);
        wait_idle(600);
        stab_en = 1'b0;
        cen_div = 1'b0;
        tick();
        tick();
        compare_txns("cendiv");

        // Busy clears on the last allowed poll: no timeout.
        busy_len = PLIM - 1;
        push(8'h11, 8'h22, 4);
        wait_idle(400);
        check("edge_err", err_timeout, 0);
        compare_txns("edge");

        // Busy stuck: both writes time out, then a normal write follows.
        busy_len = 1000;
        repeat (2) push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 400);
        wait_idle(1000);
        check("stuck_err", err_timeout, 1);
        compare_txns("stuck");
        busy_len = 0;
        push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4);
        wait_idle(100);
        check("sticky_err", err_timeout, 1);
        compare_txns("after_stuck");

        // Reset in the middle of the gap with a second request queued.
        push(8'h33, 8'h44, 4);
        push(8'h55, 8'h66, 4);
        seen_addr = 1'b0;
        in_gap = 1'b0;
        for (int i = 0; i < 50 && !in_gap; i++) begin
            if (!ym_cs_n && !ym_wr_n && !ym_addr) seen_addr = 1'b1;
            else if (seen_addr && ym_cs_n) in_gap = 1'b1;
            if (!in_gap) tick();
        end
        check("gap_reached", in_gap, 1);
        rst = 1'b1;
        #1;
        check("rstgap_cs_n", ym_cs_n, 1);
        check("rstgap_wr_n", ym_wr_n, 1);
        check("rstgap_level", level, 0);
        check("rstgap_busy", busy, 0);
        check("rstgap_err", err_timeout, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        trace.delete();
        exp_q.delete();
        busy_len = $urandom_range(0, 3);
        push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4);
        wait_idle(100);
        compare_txns("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
